onewire_slave: RTL

Clock-counted 1-wire responder: the device end of the bus driven by the team's 1-wire master, sharing its `port` line and time base.
- Detects the master's reset pulse, answers with a presence pulse and decodes one LSB-first command byte.
- On 44h it latches a 16-bit sample into its scratch register.
- On BEh it returns that register LSB-first in 16 master-initiated read slots.
- Used as the bus-side model/peripheral in board tests alongside the master.

---
 rtl/onewire_slave.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/onewire_slave.sv
// Clock-counted 1-wire responder. Answers a bus reset with presence and decodes one command byte.
// It latches a sample on 44h and returns the 16-bit scratch register LSB-first on BEh.
module onewire_slave #(
    parameter int RESET_MIN = 20000,
    parameter int PRES_WAIT = 600,
    parameter int PRES_LEN  = 4000,
    parameter int SAMPLE_T  = 3000,
    parameter int READ_HOLD = 6050
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire         port,
    input  logic [15:0] temp_in,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        conv_start,
    output logic [15:0] scratch,
    output logic        busy
);

    localparam logic [15:0] RST_C  = 16'(RESET_MIN);
    localparam logic [15:0] PW_C   = 16'(PRES_WAIT);
    localparam logic [15:0] PL_C   = 16'(PRES_LEN);
    localparam logic [12:0] SMP_C  = 13'(SAMPLE_T);
    localparam logic [12:0] HOLD_C = 13'(READ_HOLD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_PRES_WAIT,
        S_PRES_DRV,
        S_CMD_RX,
        S_TX,
        S_WAIT_RST
    } state_t;

    state_t      state_reg, state_next;
    logic        sync_reg, line_s, line_d_reg;
    logic [15:0] low_cnt_reg, low_cnt_next;
    logic [15:0] tmr_reg, tmr_next, tmr_inc;
    logic [12:0] stmr_reg, stmr_next, stmr_inc;
    logic [3:0]  bitcnt_reg, bitcnt_next;
    logic [7:0]  sh_reg, sh_next, byte_full;
    logic        slot_on_reg, slot_on_next;
    logic        wait_high_reg, wait_high_next;
    logic        oe_reg, oe_next;
    logic [7:0]  cmd_byte_reg, cmd_byte_next;
    logic        cmd_valid_reg, cmd_valid_next;
    logic        conv_start_reg, conv_start_next;
    logic [15:0] scratch_reg, scratch_next;
    logic        cnt_en, bus_rst, fall;

    // Our own drive must never look like an external low or an external fall.
    assign cnt_en  = !line_s && !oe_reg;
    assign fall    = line_d_reg && !line_s && !oe_reg;
    assign bus_rst = cnt_en && (low_cnt_reg >= RST_C - 16'd1);

    assign low_cnt_next = !cnt_en ? 16'd0 :
                          (low_cnt_reg >= RST_C) ? RST_C : low_cnt_reg + 16'd1;
    assign tmr_inc  = (tmr_reg == 16'hFFFF) ? tmr_reg : tmr_reg + 16'd1;
    assign stmr_inc = (stmr_reg == 13'h1FFF) ? stmr_reg : stmr_reg + 13'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg       <= 1'b1;
            line_s         <= 1'b1;
            line_d_reg     <= 1'b1;
            state_reg      <= S_IDLE;
            low_cnt_reg    <= '0;
            tmr_reg        <= '0;
            stmr_reg       <= '0;
            bitcnt_reg     <= '0;
            sh_reg         <= '0;
            slot_on_reg    <= 1'b0;
            wait_high_reg  <= 1'b0;
            oe_reg         <= 1'b0;
            cmd_byte_reg   <= 8'h00;
            cmd_valid_reg  <= 1'b0;
            conv_start_reg <= 1'b0;
            scratch_reg    <= 16'h0550;
        end else begin
            sync_reg       <= port;
            line_s         <= sync_reg;
            line_d_reg     <= line_s;
            state_reg      <= state_next;
            low_cnt_reg    <= low_cnt_next;
            tmr_reg        <= tmr_next;
            stmr_reg       <= stmr_next;
            bitcnt_reg     <= bitcnt_next;
            sh_reg         <= sh_next;
            slot_on_reg    <= slot_on_next;
            wait_high_reg  <= wait_high_next;
            oe_reg         <= oe_next;
            cmd_byte_reg   <= cmd_byte_next;
            cmd_valid_reg  <= cmd_valid_next;
            conv_start_reg <= conv_start_next;
            scratch_reg    <= scratch_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tmr_next        = tmr_reg;
        stmr_next       = stmr_reg;
        bitcnt_next     = bitcnt_reg;
        sh_next         = sh_reg;
        slot_on_next    = slot_on_reg;
        wait_high_next  = wait_high_reg;
        oe_next         = oe_reg;
        cmd_byte_next   = cmd_byte_reg;
        cmd_valid_next  = 1'b0;
        conv_start_next = 1'b0;
        scratch_next    = scratch_reg;
        byte_full       = sh_reg;
        byte_full[bitcnt_reg[2:0]] = line_s;

        case (state_reg)
            S_IDLE: begin
            end
            S_RST_LOW: begin
                if (line_s) begin
                    state_next = S_PRES_WAIT;
                    tmr_next   = '0;
                end
            end
            S_PRES_WAIT: begin
                tmr_next = tmr_inc;
                if (tmr_reg >= PW_C - 16'd1) begin
                    state_next = S_PRES_DRV;
                    oe_next    = 1'b1;
                    tmr_next   = '0;
                end
            end
            S_PRES_DRV: begin
                tmr_next = tmr_inc;
                if (tmr_reg >= PL_C - 16'd1) begin
                    state_next     = S_CMD_RX;
                    oe_next        = 1'b0;
                    bitcnt_next    = '0;
                    slot_on_next   = 1'b0;
                    wait_high_next = 1'b0;
                end
            end
            S_CMD_RX: begin
                if (slot_on_reg) begin
                    stmr_next = stmr_inc;
                    if (stmr_reg >= SMP_C) begin
                        sh_next        = byte_full;
                        slot_on_next   = 1'b0;
                        wait_high_next = 1'b1;
                        if (bitcnt_reg == 4'd7) begin
                            cmd_byte_next  = byte_full;
                            cmd_valid_next = 1'b1;
                            bitcnt_next    = '0;
                            case (byte_full)
                                8'h44: begin
                                    scratch_next    = temp_in;
                                    conv_start_next = 1'b1;
                                    state_next      = S_WAIT_RST;
                                end
                                8'hBE:   state_next = S_TX;
                                default: state_next = S_WAIT_RST;
                            endcase
                        end else begin
                            bitcnt_next = bitcnt_reg + 4'd1;
                        end
                    end
                end else if (wait_high_reg) begin
                    if (line_s) wait_high_next = 1'b0;
                end else if (fall) begin
                    slot_on_next = 1'b1;
                    stmr_next    = 13'd1;
                end
            end
            S_TX: begin
                if (slot_on_reg) begin
                    stmr_next = stmr_inc;
                    if (stmr_reg >= HOLD_C) begin
                        oe_next        = 1'b0;
                        slot_on_next   = 1'b0;
                        wait_high_next = 1'b1;
                        if (bitcnt_reg == 4'd15) begin
                            state_next  = S_WAIT_RST;
                            bitcnt_next = '0;
                        end else begin
                            bitcnt_next = bitcnt_reg + 4'd1;
                        end
                    end
                end else if (wait_high_reg) begin
                    if (line_s) wait_high_next = 1'b0;
                end else if (fall) begin
                    slot_on_next = 1'b1;
                    stmr_next    = 13'd1;
                    oe_next      = !scratch_reg[bitcnt_reg];
                end
            end
            S_WAIT_RST: begin
            end
            default: state_next = S_IDLE;
        endcase

        // A bus reset wins over whatever transfer was in progress.
        if (bus_rst) begin
            state_next     = S_RST_LOW;
            oe_next        = 1'b0;
            bitcnt_next    = '0;
            slot_on_next   = 1'b0;
            wait_high_next = 1'b0;
            tmr_next       = '0;
            stmr_next      = '0;
        end
    end

    assign port       = oe_reg ? 1'b0 : 1'bz;
    assign cmd_byte   = cmd_byte_reg;
    assign cmd_valid  = cmd_valid_reg;
    assign conv_start = conv_start_reg;
    assign scratch    = scratch_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule
